// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave: byte lanes, registered reads, write forwarding, wait states.
// Define AHB_SRAM_SLAVE_ERR_EN to enable the range/size/alignment ERROR response.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int WAIT_WRITE = 0,
  parameter int WAIT_READ  = 0
) (
  input  logic                  i_hclk,
  input  logic                  i_hresetn,
  input  logic                  i_hsel,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hreadyin,
  input  logic [DATA_WIDTH-1:0] i_hwdata,
  output logic                  o_hreadyout,
  output logic                  o_hresp,
  output logic [DATA_WIDTH-1:0] o_hrdata
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LNB = $clog2(NB);
  localparam int LMB = $clog2(MEM_BYTES);
  localparam int NW  = MEM_BYTES / NB;
  localparam logic [3:0] WW = 4'(WAIT_WRITE);
  localparam logic [3:0] WR = 4'(WAIT_READ);

  typedef enum logic [1:0] {
    S_READY, S_WAIT, S_ERR1, S_ERR2
  } state_t;

  state_t st, st_n;
  logic [3:0] cnt, cnt_n;
  logic act, d_write;
  logic [LMB-1:0] d_off;
  logic [2:0] d_sz;

  logic acc, a_err, ld, wr;
  logic [2:0] a_sz, l_sz;
  logic [LMB-1:0] amask, a_off, l_off;
  logic [3:0] a_wait;
  logic [NB-1:0] c_be, l_be;
  logic [LMB-LNB-1:0] c_idx, l_idx;
  logic [DATA_WIDTH-1:0] rword, rdata;
  logic [DATA_WIDTH-1:0] mem [NW];

  logic unused;
  assign unused = ^{i_htrans[0], i_haddr[ADDR_WIDTH-1:LMB]};

  function automatic logic [NB-1:0] lanes(
    input logic [2:0] sz,
    input logic [LNB-1:0] base
  );
    logic [NB-1:0] m;
    m = NB'((1 << (1 << sz)) - 1);
    return m << base;
  endfunction

  assign o_hreadyout = (st != S_WAIT) && (st != S_ERR1);
`ifdef AHB_SRAM_SLAVE_ERR_EN
  assign o_hresp = (st == S_ERR1) || (st == S_ERR2);
`else
  assign o_hresp = 1'b0;
`endif

  assign acc = i_hsel & i_hreadyin & i_htrans[1] & o_hreadyout;
  assign a_wait = i_hwrite ? WW : WR;

  // Address normalisation: clip size, force alignment, wrap offset
  always_comb begin
    a_sz  = (i_hsize > 3'(LNB)) ? 3'(LNB) : i_hsize;
    amask = LMB'((1 << a_sz) - 1);
    a_off = i_haddr[LMB-1:0] & ~amask;
    a_err = 1'b0;
`ifdef AHB_SRAM_SLAVE_ERR_EN
    a_err = (|i_haddr[ADDR_WIDTH-1:LMB])
          | (i_hsize > 3'(LNB))
          | (|(i_haddr[LMB-1:0] & amask));
`endif
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    unique case (st)
      S_READY: st_n = S_READY;
      S_WAIT: begin
        if (cnt == 4'd0) st_n = S_READY;
        else cnt_n = cnt - 4'd1;
      end
`ifdef AHB_SRAM_SLAVE_ERR_EN
      S_ERR1: st_n = S_ERR2;
      S_ERR2: st_n = S_READY;
`endif
      default: st_n = S_READY;
    endcase
    if (acc) begin
      if (a_err) st_n = S_ERR1;
      else if (a_wait != 4'd0) begin
        st_n  = S_WAIT;
        cnt_n = a_wait - 4'd1;
      end else st_n = S_READY;
    end
  end

  assign wr    = act && (st == S_READY) && d_write;
  assign c_be  = lanes(d_sz, d_off[LNB-1:0]);
  assign c_idx = d_off[LMB-1:LNB];

  // Read loads at accept (zero wait) or on leaving WAIT
  assign ld = (acc && !i_hwrite && (a_err || a_wait == 4'd0))
            || (st == S_WAIT && cnt == 4'd0 && !d_write);
  assign l_off = (st == S_WAIT) ? d_off : a_off;
  assign l_sz  = (st == S_WAIT) ? d_sz : a_sz;
  assign l_idx = l_off[LMB-1:LNB];
  assign l_be  = lanes(l_sz, l_off[LNB-1:0]);

  always_comb begin
    rword = mem[l_idx];
    rdata = '0;
    for (int k = 0; k < NB; k++) begin
      if (l_be[k]) begin
        if (wr && c_idx == l_idx && c_be[k])
          rdata[8*k +: 8] = i_hwdata[8*k +: 8];
        else
          rdata[8*k +: 8] = rword[8*k +: 8];
      end
    end
    if (acc && a_err) rdata = '0;
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      st       <= S_READY;
      cnt      <= '0;
      act      <= 1'b0;
      d_write  <= 1'b0;
      d_off    <= '0;
      d_sz     <= '0;
      o_hrdata <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      if (acc) begin
        act     <= !a_err;
        d_write <= i_hwrite;
        d_off   <= a_off;
        d_sz    <= a_sz;
      end else if (o_hreadyout) begin
        act <= 1'b0;
      end
      if (ld) o_hrdata <= rdata;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge i_hclk) begin
    if (wr) begin
      for (int k = 0; k < NB; k++)
        if (c_be[k]) mem[c_idx][8*k +: 8] <= i_hwdata[8*k +: 8];
    end
  end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-lite memory slave, the next generation of the team's AHB slave model. It adds:
- data widths of 32 or 64 bits;
- little-endian byte-lane addressing;
- a registered read path with write-to-read forwarding;
- a state-machine-driven wait-state generator;
- a spec-compliant two-cycle ERROR response.

It sits behind the AHB-lite decoder/multiplexor as a generic test and scratch memory target.

## Interface
- ADDR_WIDTH, 32: address bus width.
- DATA_WIDTH, 32: data bus width; legal values are 32 or 64. NB = DATA_WIDTH/8.
- MEM_BYTES, 4096: memory size in bytes; power of two, ≥ NB.
- WAIT_WRITE, 0: wait states inserted on write data phases (0..15).
- WAIT_READ, 0: wait states inserted on read data phases (0..15).

Ports:
- i_hclk  in  1: clock; all timing is on the rising edge.
- i_hresetn  in  1: reset. One clock; reset is asynchronous and active-low.
- i_hsel  in  1: slave select from the decoder.
- i_haddr  in  ADDR_WIDTH: address-phase address.
- i_hwrite  in  1: 1 = write, 0 = read.
- i_hsize  in  3: transfer size. 0 = byte, 1 = half, 2 = word, 3 = dword (dword only when DATA_WIDTH = 64).
- i_htrans  in  2: IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
- i_hreadyin  in  1: bus HREADY.
- i_hwdata  in  DATA_WIDTH: write data, valid in the data phase.
- o_hreadyout  out  1: 0 inserts a wait state.
- o_hresp  out  1: 0 = OKAY, 1 = ERROR.
- o_hrdata  out  DATA_WIDTH: registered read data.

## Operation

Transfer acceptance:
- A transfer is accepted on an edge where i_hsel & i_hreadyin & i_htrans[1].
- IDLE and BUSY transfers, and unselected cycles, are ignored. They produce zero-wait OKAY.
- On accept, register the offset (i_haddr mod MEM_BYTES, plus the out-of-range flag), the size, and the direction.

Byte lanes:
- Lane base = offset[log2(NB)-1:0].
- The transfer covers 2^size bytes starting at that lane.
- Byte k of memory maps to lane k mod NB (little-endian).

State machine:
- **READY** (reset state): o_hreadyout = 1.
- READY → **WAIT** on accepting a transfer whose direction's wait count W > 0.
  - In WAIT, o_hreadyout = 0 for exactly W cycles, counted by a 4-bit counter.
  - WAIT → DATA-final cycle: o_hreadyout = 1, then back to READY.
  - Back-to-back accepts are allowed in the final data-phase cycle (pipelined).
- Error path: READY/WAIT → **ERR1** → **ERR2** → READY.
  - ERR1: o_hreadyout = 0, o_hresp = 1.
  - ERR2: o_hreadyout = 1, o_hresp = 1.
  - An error transfer gets no wait states before ERR1.

Error conditions (only with the configuration macro defined):
- offset ≥ MEM_BYTES (upper i_haddr bits above log2(MEM_BYTES) are nonzero);
- 2^size > NB;
- address not aligned to 2^size.

An errored transfer writes nothing and returns o_hrdata = 0.

Writes:
- Bytes are committed from i_hwdata lanes on the edge ending the final (o_hreadyout = 1) data-phase cycle.
- Lanes outside the transfer are untouched.

Reads:
- o_hrdata is loaded on the edge that begins the final data-phase cycle.
- Addressed lanes carry memory data; all other lanes are 0.
- o_hrdata holds its value until the next read load.

Forwarding:
- If a read loads in the same cycle that a write commits to the same NB-aligned word, the written lanes are forwarded from i_hwdata.
- Zero-wait write followed by read of the same address must return the new data.

Reset and memory contents:
- Memory is not reset; contents survive i_hresetn assertion.
- Reset mid-transfer aborts it: no write commit, state returns to READY.

## Timing
- Reset values: o_hreadyout = 1, o_hresp = 0, o_hrdata = 0, state READY, wait counter 0.
- Read latency: address phase at edge N; data valid after edge N+W, sampled by the master at edge N+W+1.
- Write: memory updated at edge N+W+1 and visible to a read accepted at that same edge via forwarding.
- Error: o_hresp = 1 for exactly 2 cycles; o_hreadyout low only in the first.
- While o_hreadyout = 0, address-phase inputs are ignored.

## Configuration
- AHB_SRAM_SLAVE_ERR_EN defined: all three error checks are active and the ERR1/ERR2 states exist.
- Not defined:
  - o_hresp is tied to 0 and the ERR states are removed;
  - offsets wrap modulo MEM_BYTES;
  - misaligned low address bits within the size are forced to 0;
  - an oversize hsize is clipped to NB.

## Test plan
- Zero-wait write/read (DATA_WIDTH=32): write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back → o_hrdata = 0xDEADBEEF via forwarding; read byte at 0x11 → 0x0000BE00.
- Wait states (WAIT_WRITE=2, WAIT_READ=3): a write holds o_hreadyout low 2 cycles and a read holds it low 3 cycles; data is correct and the counter is back to 0 afterwards.
- DATA_WIDTH=64:
  - dword write 0x0123456789ABCDEF to 0x8;
  - halfword read at 0xC → 0x0000456700000000 (lanes 4-5 = 0x4567, all other lanes 0).
- With AHB_SRAM_SLAVE_ERR_EN: word access at 0x1002 (misaligned) and at 0x2000 (MEM_BYTES=4096) → cycle 1: hreadyout 0 / hresp 1; cycle 2: hreadyout 1 / hresp 1; memory unchanged.
- IDLE and BUSY transfers while selected → o_hreadyout = 1, o_hresp = 0, no memory change.
- Assert i_hresetn low during the wait states of a write to 0x20:
  - outputs return to reset values;
  - mem[0x20] keeps its old value;
  - the next transfer completes normally.
